// File: rtl/partial_product_streamer_if.sv
// rtl/partial_product_streamer_if.sv - operand/result handshake bundle for partial_product_streamer
interface partial_product_streamer_if #(
    parameter int EXPONENT   = 2,
    parameter int DATA_WIDTH = 8,
    parameter int A_WIDTH    = 4
);
    localparam int N = 2 ** EXPONENT;

    logic                    in_valid;
    logic                    in_ready;
    logic [A_WIDTH-1:0]      a;
    logic [N-1:0]            b;
    logic                    out_valid;
    logic                    out_ready;
    logic [N*DATA_WIDTH-1:0] pp_vector;
    logic                    busy;

    // Operand producer / result consumer side
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, pp_vector, busy
    );

    // Streamer side
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, pp_vector, busy
    );
endinterface

// File: rtl/partial_product_streamer.sv
// rtl/partial_product_streamer.sv - sequential partial-product generator feeding the adder tree
module partial_product_streamer #(
    parameter int EXPONENT   = 2,
    parameter int DATA_WIDTH = 8,
    parameter int A_WIDTH    = 4
) (
    input  logic clk,
    input  logic rst_n,
    partial_product_streamer_if.slave bus
);
    localparam int N     = 2 ** EXPONENT;
    localparam int IDX_W = (EXPONENT > 0) ? EXPONENT : 1;
    // Shift is done wide enough that no multiplicand bit is lost before truncation
    localparam int SH_W  = (DATA_WIDTH > A_WIDTH + N) ? DATA_WIDTH : (A_WIDTH + N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [A_WIDTH-1:0]      a_q, a_d;
    logic [N-1:0]            b_q, b_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [N*DATA_WIDTH-1:0] pp_q, pp_d;

    logic [SH_W-1:0]         shifted;
    logic [DATA_WIDTH-1:0]   slot_val;

    // Current partial product: zero-extended multiplicand shifted by the slot index
    always_comb begin
        shifted  = SH_W'(a_q) << idx_q;
        slot_val = b_q[idx_q] ? shifted[DATA_WIDTH-1:0] : '0;
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        pp_d    = pp_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    idx_d   = '0;
                    pp_d    = '0;
                    state_d = GEN;
                end
            end
            GEN: begin
                pp_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = slot_val;
                // Index stops at the last slot rather than wrapping
                if (idx_q == IDX_W'(N - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            pp_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            pp_q    <= pp_d;
        end
    end

    // Handshake outputs decoded straight from state
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
        bus.pp_vector = pp_q;
    end
endmodule

// File: tb/tb_partial_product_streamer.sv
// tb/tb_partial_product_streamer.sv - scoreboard bench for partial_product_streamer
module tb_partial_product_streamer;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;

    typedef struct {
        logic [31:0] vec;
        logic [7:0]  sum;
    } exp8_t;

    typedef struct {
        logic [23:0] vec;
        logic [5:0]  sum;
    } exp6_t;

    exp8_t q8[$];
    exp6_t q6[$];

    partial_product_streamer_if #(.EXPONENT(2), .DATA_WIDTH(8), .A_WIDTH(4)) ifc8 ();
    partial_product_streamer_if #(.EXPONENT(2), .DATA_WIDTH(6), .A_WIDTH(4)) ifc6 ();

    partial_product_streamer #(.EXPONENT(2), .DATA_WIDTH(8), .A_WIDTH(4)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc8.slave)
    );

    partial_product_streamer #(.EXPONENT(2), .DATA_WIDTH(6), .A_WIDTH(4)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc6.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push8(input logic [31:0] vec, input logic [7:0] sum);
        exp8_t e;
        e.vec = vec;
        e.sum = sum;
        q8.push_back(e);
    endtask

    // Scoreboard monitor for the 8-bit instance: compare on every completed output handshake
    always @(negedge clk) begin
        if (rst_n && ifc8.out_valid && ifc8.out_ready) begin
            if (q8.size() == 0) begin
                check("unexpected_out8", 64'(ifc8.pp_vector), 64'hDEAD);
            end else begin
                exp8_t e;
                logic [7:0] s;
                e = q8.pop_front();
                s = ifc8.pp_vector[7:0] + ifc8.pp_vector[15:8]
                  + ifc8.pp_vector[23:16] + ifc8.pp_vector[31:24];
                check("vec8", 64'(ifc8.pp_vector), 64'(e.vec));
                check("sum8", 64'(s), 64'(e.sum));
            end
        end
    end

    // Scoreboard monitor for the 6-bit instance
    always @(negedge clk) begin
        if (rst_n && ifc6.out_valid && ifc6.out_ready) begin
            if (q6.size() == 0) begin
                check("unexpected_out6", 64'(ifc6.pp_vector), 64'hDEAD);
            end else begin
                exp6_t e;
                logic [5:0] s;
                e = q6.pop_front();
                s = ifc6.pp_vector[5:0] + ifc6.pp_vector[11:6]
                  + ifc6.pp_vector[17:12] + ifc6.pp_vector[23:18];
                check("vec6", 64'(ifc6.pp_vector), 64'(e.vec));
                check("sum6", 64'(s), 64'(e.sum));
            end
        end
    end

    // Present a pair, wait for acceptance, push the expectation before the accepting edge
    task automatic send8(input logic [3:0] av, input logic [3:0] bv,
                         input logic [31:0] vec, input logic [7:0] sum);
        int n;
        n = 0;
        ifc8.in_valid = 1'b1;
        ifc8.a        = av;
        ifc8.b        = bv;
        forever begin
            @(negedge clk);
            if (ifc8.in_ready) break;
            n++;
            if (n > 50) begin
                check("accept_timeout", 64'(0), 64'(1));
                break;
            end
        end
        push8(vec, sum);
        @(posedge clk);
        #1;
        ifc8.in_valid = 1'b0;
    endtask

    task automatic drain8();
        int n;
        n = 0;
        while (q8.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain8_empty", 64'(q8.size()), 64'(0));
    endtask

    logic [31:0] held;
    int          k;
    int          last_acc;
    int          zero_ready;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        ifc8.in_valid = 1'b0; ifc8.a = '0; ifc8.b = '0; ifc8.out_ready = 1'b0;
        ifc6.in_valid = 1'b0; ifc6.a = '0; ifc6.b = '0; ifc6.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(ifc8.in_ready), 64'(1));
        check("rst_out_valid", 64'(ifc8.out_valid), 64'(0));
        check("rst_busy", 64'(ifc8.busy), 64'(0));
        check("rst_pp", 64'(ifc8.pp_vector), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // a=B, b=1010 with out_ready low: latency, stall stability, release
        @(posedge clk);
        #1;
        send8(4'hB, 4'b1010, 32'h5800_1600, 8'h6E);
        k = 0;
        forever begin
            @(posedge clk);
            k++;
            #1;
            if (ifc8.out_valid || k > 20) break;
        end
        check("latency", 64'(k), 64'(4));
        check("busy_done", 64'(ifc8.busy), 64'(1));
        check("in_ready_done", 64'(ifc8.in_ready), 64'(0));
        held = ifc8.pp_vector;
        check("pp_first", 64'(held), 64'h5800_1600);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 64'(ifc8.out_valid), 64'(1));
            check("stall_stable", 64'(ifc8.pp_vector), 64'h5800_1600);
        end
        ifc8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc8.out_ready = 1'b0;
        check("post_hs_valid", 64'(ifc8.out_valid), 64'(0));
        check("post_hs_ready", 64'(ifc8.in_ready), 64'(1));
        check("post_hs_busy", 64'(ifc8.busy), 64'(0));
        check("post_hs_pp_held", 64'(ifc8.pp_vector), 64'h5800_1600);
        check("q_after_first", 64'(q8.size()), 64'(0));

        // in_valid held with changing operands during GEN
        ifc8.out_ready = 1'b1;
        ifc8.in_valid  = 1'b1;
        ifc8.a = 4'h3;
        ifc8.b = 4'b0101;
        k = 0;
        forever begin
            @(negedge clk);
            if (ifc8.in_ready || k > 20) break;
            k++;
        end
        push8(32'h000C_0003, 8'd15);
        @(posedge clk);
        #1;
        ifc8.a = 4'h7;
        ifc8.b = 4'b1001;
        zero_ready = 0;
        forever begin
            @(negedge clk);
            if (ifc8.in_ready || zero_ready > 20) break;
            zero_ready++;
        end
        check("in_ready_low_cycles", 64'(zero_ready), 64'(5));
        push8(32'h3800_0007, 8'd63);
        @(posedge clk);
        #1;
        ifc8.in_valid = 1'b0;
        drain8();

        // Narrow instance: truncation of the top slot
        @(posedge clk);
        #1;
        ifc6.in_valid = 1'b1;
        ifc6.a = 4'hF;
        ifc6.b = 4'b1000;
        begin
            exp6_t e;
            e.vec = 24'hE0_0000;
            e.sum = 6'h38;
            q6.push_back(e);
        end
        @(posedge clk);
        #1;
        ifc6.in_valid = 1'b0;
        k = 0;
        while (q6.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("drain6_empty", 64'(q6.size()), 64'(0));

        // Reset mid-GEN after two slots
        ifc8.out_ready = 1'b0;
        @(posedge clk);
        #1;
        send8(4'h5, 4'hF, 32'h0, 8'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_gen_busy", 64'(ifc8.busy), 64'(1));
        check("mid_gen_partial", 64'(ifc8.pp_vector), 64'h0000_0A05);
        #2;
        rst_n = 1'b0;
        #1;
        q8.delete();
        check("arst_pp", 64'(ifc8.pp_vector), 64'(0));
        check("arst_valid", 64'(ifc8.out_valid), 64'(0));
        check("arst_ready", 64'(ifc8.in_ready), 64'(1));
        check("arst_busy", 64'(ifc8.busy), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ifc8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send8(4'h3, 4'hF, 32'h180C_0603, 8'd45);
        drain8();

        // Back-to-back stream, a=1..8, b=F, out_ready high
        @(posedge clk);
        #1;
        ifc8.in_valid = 1'b1;
        ifc8.b = 4'hF;
        ifc8.a = 4'd1;
        last_acc = 0;
        for (int i = 1; i <= 8; i++) begin
            logic [7:0] av;
            logic [7:0] ev;
            av = 8'(i);
            k = 0;
            forever begin
                @(negedge clk);
                if (ifc8.in_ready || k > 30) break;
                k++;
            end
            push8({8'(av * 8), 8'(av * 4), 8'(av * 2), av}, 8'(av * 15));
            if (i > 1) check("accept_interval", 64'(cyc - last_acc), 64'(6));
            last_acc = cyc;
            @(posedge clk);
            #1;
            if (i < 8) ifc8.a = 4'(i + 1);
            else ifc8.in_valid = 1'b0;
            ev = 8'(i);
        end
        drain8();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
